// File: rtl/j_wgt_shift_sched_pkg.sv
// Shared definitions for the weight-shifter tile scheduler: state encodings,
// column count, error bit positions and a constant-safe clog2.
package j_wgt_shift_sched_pkg;

    localparam int NUM_COL = 8;

    localparam int ERR_BAD_CFG  = 0;
    localparam int ERR_ADDR_OVF = 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE  = 3'd0;
    localparam state_t ST_LOAD  = 3'd1;
    localparam state_t ST_START = 3'd2;
    localparam state_t ST_GAP   = 3'd3;
    localparam state_t ST_RUN   = 3'd4;
    localparam state_t ST_HOLD  = 3'd5;
    localparam state_t ST_FIN   = 3'd6;

    function automatic int clog2(input longint unsigned value);
        longint unsigned v;
        int w;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w = w + 1;
            v = v >> 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/j_wgt_shift_sched_if.sv
// Bundle between the layer controller / weight shifter / array and the tile
// scheduler. The scheduler takes the slave view, its environment the master.
interface j_wgt_shift_sched_if #(
    parameter int ADDR_W  = 18,
    parameter int TILE_W  = 16,
    parameter int NUM_COL = j_wgt_shift_sched_pkg::NUM_COL
) ();

    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [TILE_W-1:0]         cfg_num_tiles;
    logic [ADDR_W-1:0]         cfg_base_addr;
    logic [ADDR_W-1:0]         cfg_tile_len;
    logic [ADDR_W-1:0]         cfg_img_size;
    logic [NUM_COL-1:0]        cfg_col_mask;
    logic                      abort;
    logic                      shift_start;
    logic                      shift_idle;
    logic [ADDR_W*NUM_COL-1:0] end_addr;
    logic [ADDR_W-1:0]         img_size;
    logic                      tile_done;
    logic                      tile_ready;
    logic [TILE_W-1:0]         tile_idx;
    logic                      layer_done;
    logic [1:0]                err;

    modport master (
        output cfg_valid, cfg_num_tiles, cfg_base_addr, cfg_tile_len,
               cfg_img_size, cfg_col_mask, abort, shift_idle, tile_ready,
        input  cfg_ready, shift_start, end_addr, img_size, tile_done,
               tile_idx, layer_done, err
    );

    modport slave (
        input  cfg_valid, cfg_num_tiles, cfg_base_addr, cfg_tile_len,
               cfg_img_size, cfg_col_mask, abort, shift_idle, tile_ready,
        output cfg_ready, shift_start, end_addr, img_size, tile_done,
               tile_idx, layer_done, err
    );

endinterface

// File: rtl/j_wgt_tile_addr_gen.sv
// Tile base accumulator and end-address computation. The base is one bit
// wider than the SRAM address so running past the end shows up as overflow
// instead of silently wrapping back to low addresses.
module j_wgt_tile_addr_gen
    import j_wgt_shift_sched_pkg::*;
#(
    parameter int SRAM_DEPTH = 256*256*4,
    parameter int ADDR_W     = clog2(SRAM_DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              load,
    input  logic              advance,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] tile_len,
    output logic [ADDR_W-1:0] tile_end,
    output logic              ovf
);

    localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(SRAM_DEPTH - 1);

    logic [ADDR_W:0] tile_base;
    logic [ADDR_W:0] end_wide;

    // Base restarts on config accept and steps by one tile on each advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tile_base <= '0;
        end else if (load) begin
            tile_base <= {1'b0, base_addr};
        end else if (advance) begin
            tile_base <= tile_base + {1'b0, tile_len};
        end
    end

    assign end_wide = tile_base + {1'b0, tile_len} - (ADDR_W+1)'(1);
    assign tile_end = end_wide[ADDR_W-1:0];
    assign ovf      = end_wide > LAST_WORD;

endmodule

// File: rtl/j_wgt_shift_sched.sv
// Tile scheduler for the 8-column weight shifter. Takes one layer config,
// then per tile programs end_addr, pulses shift_start, waits out the
// shifter and handshakes with the array before moving on.
//
//  state | meaning
//  IDLE  | cfg_ready high, waiting for a layer config
//  LOAD  | compute tile end address, check overflow / pending abort
//  START | one-cycle shift_start pulse
//  GAP   | START_GAP cycles while the shifter registers its start
//  RUN   | wait for shift_idle
//  HOLD  | tile_done high until tile_ready
//  FIN   | one-cycle layer_done pulse
module j_wgt_shift_sched
    import j_wgt_shift_sched_pkg::*;
#(
    parameter int SRAM_DEPTH = 256*256*4,
    parameter int TILE_W     = 16,
    parameter int START_GAP  = 3
) (
    input logic                clk,
    input logic                reset_n,
    j_wgt_shift_sched_if.slave bus
);

    localparam int SRAM_ADDR_W = clog2(SRAM_DEPTH);
    localparam int GAP_W       = (START_GAP > 1) ? clog2(START_GAP) : 1;

    state_t                          state;
    state_t                          state_nxt;
    logic [GAP_W-1:0]                gap_cnt;
    logic [TILE_W-1:0]               num_tiles;
    logic [SRAM_ADDR_W-1:0]          tile_len;
    logic [NUM_COL-1:0]              col_mask;
    logic [SRAM_ADDR_W-1:0]          img_size_q;
    logic [TILE_W-1:0]               tile_idx_q;
    logic [SRAM_ADDR_W*NUM_COL-1:0]  end_addr_q;
    logic [1:0]                      err_q;
    logic                            abort_q;

    logic                            accept;
    logic                            bad_cfg;
    logic                            abort_seen;
    logic                            last_tile;
    logic                            tile_exit;
    logic                            advance;
    logic [SRAM_ADDR_W-1:0]          tile_end;
    logic                            tile_ovf;

    assign accept     = (state == ST_IDLE) && bus.cfg_valid;
    assign bad_cfg    = (bus.cfg_num_tiles == '0) || (bus.cfg_tile_len == '0);
    assign abort_seen = abort_q || bus.abort;
    assign last_tile  = tile_idx_q == (num_tiles - TILE_W'(1));
    assign tile_exit  = (state == ST_HOLD) && bus.tile_ready;
    assign advance    = tile_exit && !last_tile && !abort_seen;

    j_wgt_tile_addr_gen #(
        .SRAM_DEPTH (SRAM_DEPTH),
        .ADDR_W     (SRAM_ADDR_W)
    ) u_addr_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (accept),
        .advance   (advance),
        .base_addr (bus.cfg_base_addr),
        .tile_len  (tile_len),
        .tile_end  (tile_end),
        .ovf       (tile_ovf)
    );

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.cfg_valid) state_nxt = bad_cfg ? ST_FIN : ST_LOAD;
            ST_LOAD:  state_nxt = (tile_ovf || abort_seen) ? ST_FIN : ST_START;
            ST_START: state_nxt = ST_GAP;
            ST_GAP:   if (gap_cnt == '0) state_nxt = ST_RUN;
            ST_RUN:   if (bus.shift_idle) state_nxt = ST_HOLD;
            ST_HOLD:  if (bus.tile_ready) state_nxt = (last_tile || abort_seen) ? ST_FIN : ST_LOAD;
            ST_FIN:   state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // Down-counter that holds off shift_idle sampling right after a start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            gap_cnt <= '0;
        end else if (state == ST_START) begin
            gap_cnt <= GAP_W'(START_GAP - 1);
        end else if (state == ST_GAP && gap_cnt != '0) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
        end
    end

    // Layer configuration captured on accept.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            num_tiles  <= '0;
            tile_len   <= '0;
            col_mask   <= '0;
            img_size_q <= '0;
        end else if (accept) begin
            num_tiles  <= bus.cfg_num_tiles;
            tile_len   <= bus.cfg_tile_len;
            col_mask   <= bus.cfg_col_mask;
            img_size_q <= bus.cfg_img_size;
        end
    end

    // Tile index: zero on accept, steps only when another tile follows.
    always_ff @(posedge clk) begin
        if (!reset_n)     tile_idx_q <= '0;
        else if (accept)  tile_idx_q <= '0;
        else if (advance) tile_idx_q <= tile_idx_q + TILE_W'(1);
    end

    // Sticky error flags, restarted by each accepted config.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            err_q <= '0;
        end else if (accept) begin
            err_q <= '0;
            err_q[ERR_BAD_CFG] <= bad_cfg;
        end else if (state == ST_LOAD && tile_ovf) begin
            err_q[ERR_ADDR_OVF] <= 1'b1;
        end
    end

    // Abort is remembered until the layer ends so a short pulse is not lost.
    always_ff @(posedge clk) begin
        if (!reset_n)                             abort_q <= 1'b0;
        else if (accept)                          abort_q <= 1'b0;
        else if (state != ST_IDLE && bus.abort)   abort_q <= 1'b1;
    end

    // Per-column end addresses, written only in LOAD so they stay put through RUN.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            end_addr_q <= '0;
        end else if (state == ST_LOAD && !tile_ovf) begin
            for (int c = 0; c < NUM_COL; c++) begin
                end_addr_q[c*SRAM_ADDR_W +: SRAM_ADDR_W] <= col_mask[c] ? tile_end : '0;
            end
        end
    end

    assign bus.cfg_ready   = state == ST_IDLE;
    assign bus.shift_start = state == ST_START;
    assign bus.tile_done   = state == ST_HOLD;
    assign bus.layer_done  = state == ST_FIN;
    assign bus.end_addr    = end_addr_q;
    assign bus.img_size    = img_size_q;
    assign bus.tile_idx    = tile_idx_q;
    assign bus.err         = err_q;

endmodule

// File: tb/tb_j_wgt_shift_sched.sv
// Directed bench for the weight-shifter tile scheduler. A small shifter
// model answers each start pulse: shift_idle drops two cycles after the
// start is seen and returns busy_len cycles later.
module tb_j_wgt_shift_sched;
    import j_wgt_shift_sched_pkg::*;

    localparam int DEPTH = 256*256*4;
    localparam int AW    = 18;
    localparam int TW    = 16;
    localparam int EW    = AW*NUM_COL;

    typedef logic [159:0] cv_t;

    logic clk;
    logic reset_n;

    int n_cmp = 0;
    int n_mis = 0;
    int start_cnt = 0;
    int busy_len = 20;
    int sh_cnt = 0;
    bit sh_active = 0;

    j_wgt_shift_sched_if #(.ADDR_W(AW), .TILE_W(TW), .NUM_COL(NUM_COL)) bus ();

    j_wgt_shift_sched #(
        .SRAM_DEPTH (DEPTH),
        .TILE_W     (TW),
        .START_GAP  (3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shifter model.
    always @(negedge clk) begin
        if (!reset_n) begin
            sh_active = 0;
            bus.shift_idle = 1'b1;
        end else if (bus.shift_start) begin
            start_cnt = start_cnt + 1;
            sh_cnt = 0;
            sh_active = 1;
        end else if (sh_active) begin
            sh_cnt = sh_cnt + 1;
            if (sh_cnt == 2) bus.shift_idle = 1'b0;
            if (sh_cnt == 2 + busy_len) begin
                bus.shift_idle = 1'b1;
                sh_active = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [EW-1:0] exp_end(input logic [7:0] mask, input int val);
        logic [EW-1:0] r;
        r = '0;
        for (int c = 0; c < NUM_COL; c++) begin
            if (mask[c]) r[c*AW +: AW] = AW'(val);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input cv_t obs, input cv_t exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_cfg(input int ntiles, input int base, input int len,
                            input int img, input logic [7:0] mask);
        bus.cfg_num_tiles = TW'(ntiles);
        bus.cfg_base_addr = AW'(base);
        bus.cfg_tile_len  = AW'(len);
        bus.cfg_img_size  = AW'(img);
        bus.cfg_col_mask  = mask;
        bus.cfg_valid     = 1'b1;
        chk("cfg_ready_idle", cv_t'(bus.cfg_ready), cv_t'(1));
        @(negedge clk);
        bus.cfg_valid     = 1'b0;
    endtask

    task automatic wait_tile_done(input int max, output int n);
        n = 0;
        while (bus.tile_done !== 1'b1 && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("tile_done_seen", cv_t'(bus.tile_done), cv_t'(1));
    endtask

    task automatic pulse_ready();
        bus.tile_ready = 1'b1;
        @(negedge clk);
        bus.tile_ready = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_cfg_ready",   cv_t'(bus.cfg_ready),   cv_t'(1));
        chk("rst_shift_start", cv_t'(bus.shift_start), cv_t'(0));
        chk("rst_tile_done",   cv_t'(bus.tile_done),   cv_t'(0));
        chk("rst_layer_done",  cv_t'(bus.layer_done),  cv_t'(0));
        chk("rst_end_addr",    cv_t'(bus.end_addr),    cv_t'(0));
        chk("rst_img_size",    cv_t'(bus.img_size),    cv_t'(0));
        chk("rst_tile_idx",    cv_t'(bus.tile_idx),    cv_t'(0));
        chk("rst_err",         cv_t'(bus.err),         cv_t'(0));
    endtask

    initial begin
        int n;
        int s0;

        reset_n           = 1'b0;
        bus.cfg_valid     = 1'b0;
        bus.cfg_num_tiles = '0;
        bus.cfg_base_addr = '0;
        bus.cfg_tile_len  = '0;
        bus.cfg_img_size  = '0;
        bus.cfg_col_mask  = '0;
        bus.abort         = 1'b0;
        bus.tile_ready    = 1'b0;
        cyc(3);
        check_reset_vals();
        reset_n = 1'b1;
        cyc(1);

        // Single tile, all columns, exact start-to-done latency.
        s0 = start_cnt;
        busy_len = 20;
        send_cfg(1, 0, 16, 77, 8'hFF);
        wait_tile_done(60, n);
        chk("t1_latency",  cv_t'(n), cv_t'(24));
        chk("t1_end_addr", cv_t'(bus.end_addr), cv_t'(exp_end(8'hFF, 15)));
        chk("t1_img_size", cv_t'(bus.img_size), cv_t'(77));
        chk("t1_tile_idx", cv_t'(bus.tile_idx), cv_t'(0));
        chk("t1_starts",   cv_t'(start_cnt - s0), cv_t'(1));
        cyc(3);
        chk("t1_done_held", cv_t'(bus.tile_done), cv_t'(1));
        pulse_ready();
        chk("t1_done_drop",  cv_t'(bus.tile_done),  cv_t'(0));
        chk("t1_layer_done", cv_t'(bus.layer_done), cv_t'(1));
        cyc(1);
        chk("t1_layer_pulse", cv_t'(bus.layer_done), cv_t'(0));

        // Three tiles with base 100, len 32 and a slow array.
        s0 = start_cnt;
        busy_len = 4;
        send_cfg(3, 100, 32, 50, 8'hFF);
        for (int t = 0; t < 3; t++) begin
            wait_tile_done(60, n);
            chk("t2_tile_idx", cv_t'(bus.tile_idx), cv_t'(t));
            chk("t2_end_addr", cv_t'(bus.end_addr), cv_t'(exp_end(8'hFF, 100 + 32*t + 31)));
            cyc(5);
            chk("t2_done_held", cv_t'(bus.tile_done), cv_t'(1));
            pulse_ready();
            chk("t2_done_drop",  cv_t'(bus.tile_done),  cv_t'(0));
            chk("t2_layer_done", cv_t'(bus.layer_done), cv_t'(t == 2));
        end
        chk("t2_starts", cv_t'(start_cnt - s0), cv_t'(3));
        cyc(1);

        // Partial column mask.
        s0 = start_cnt;
        send_cfg(1, 0, 4, 5, 8'b0000_0101);
        wait_tile_done(60, n);
        chk("t3_end_addr", cv_t'(bus.end_addr), cv_t'(exp_end(8'b0000_0101, 3)));
        pulse_ready();
        chk("t3_layer_done", cv_t'(bus.layer_done), cv_t'(1));
        chk("t3_starts", cv_t'(start_cnt - s0), cv_t'(1));
        cyc(1);

        // Tile ending exactly on the last SRAM word is legal.
        send_cfg(1, DEPTH - 16, 16, 0, 8'hFF);
        wait_tile_done(60, n);
        chk("t4_err", cv_t'(bus.err), cv_t'(0));
        chk("t4_end_addr", cv_t'(bus.end_addr), cv_t'(exp_end(8'hFF, DEPTH - 1)));
        pulse_ready();
        chk("t4_layer_done", cv_t'(bus.layer_done), cv_t'(1));
        cyc(1);

        // Tile running past the SRAM end: overflow, no start.
        s0 = start_cnt;
        send_cfg(1, DEPTH - 8, 16, 0, 8'hFF);
        chk("t5_no_early_fin", cv_t'(bus.layer_done), cv_t'(0));
        cyc(1);
        chk("t5_layer_done", cv_t'(bus.layer_done), cv_t'(1));
        chk("t5_err", cv_t'(bus.err), cv_t'(2));
        chk("t5_no_start", cv_t'(bus.shift_start), cv_t'(0));
        cyc(1);
        chk("t5_layer_pulse", cv_t'(bus.layer_done), cv_t'(0));
        cyc(5);
        chk("t5_starts", cv_t'(start_cnt - s0), cv_t'(0));
        chk("t5_err_sticky", cv_t'(bus.err), cv_t'(2));

        // Zero tiles: bad config.
        send_cfg(0, 0, 16, 0, 8'hFF);
        chk("t6_layer_done", cv_t'(bus.layer_done), cv_t'(1));
        chk("t6_err", cv_t'(bus.err), cv_t'(1));
        cyc(1);
        chk("t6_cfg_ready", cv_t'(bus.cfg_ready), cv_t'(1));

        // Abort during RUN of tile 0 of 4.
        s0 = start_cnt;
        busy_len = 20;
        send_cfg(4, 0, 16, 0, 8'hFF);
        chk("t7_err_cleared", cv_t'(bus.err), cv_t'(0));
        cyc(8);
        bus.abort = 1'b1;
        cyc(1);
        bus.abort = 1'b0;
        wait_tile_done(60, n);
        chk("t7_tile_idx", cv_t'(bus.tile_idx), cv_t'(0));
        pulse_ready();
        chk("t7_layer_done", cv_t'(bus.layer_done), cv_t'(1));
        cyc(5);
        chk("t7_starts", cv_t'(start_cnt - s0), cv_t'(1));
        chk("t7_cfg_ready", cv_t'(bus.cfg_ready), cv_t'(1));

        // Config offered mid-layer is ignored; abort from the last layer is gone.
        s0 = start_cnt;
        send_cfg(2, 0, 16, 33, 8'hFF);
        cyc(8);
        bus.cfg_num_tiles = TW'(5);
        bus.cfg_base_addr = AW'(500);
        bus.cfg_tile_len  = AW'(8);
        bus.cfg_img_size  = AW'(99);
        bus.cfg_valid     = 1'b1;
        chk("t8_cfg_ready_busy", cv_t'(bus.cfg_ready), cv_t'(0));
        cyc(2);
        bus.cfg_valid = 1'b0;
        for (int t = 0; t < 2; t++) begin
            wait_tile_done(60, n);
            chk("t8_tile_idx", cv_t'(bus.tile_idx), cv_t'(t));
            chk("t8_end_addr", cv_t'(bus.end_addr), cv_t'(exp_end(8'hFF, 16*t + 15)));
            pulse_ready();
        end
        chk("t8_layer_done", cv_t'(bus.layer_done), cv_t'(1));
        chk("t8_img_size", cv_t'(bus.img_size), cv_t'(33));
        chk("t8_starts", cv_t'(start_cnt - s0), cv_t'(2));
        cyc(1);

        // Reset asserted while in GAP.
        send_cfg(1, 0, 16, 44, 8'hFF);
        cyc(1);
        chk("t9_start", cv_t'(bus.shift_start), cv_t'(1));
        cyc(1);
        reset_n = 1'b0;
        cyc(1);
        check_reset_vals();
        cyc(1);
        reset_n = 1'b1;
        cyc(2);
        chk("t9_cfg_ready", cv_t'(bus.cfg_ready), cv_t'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
